// File: rtl/hdc_bundle_encoder.sv
// hdc_bundle_encoder
//
// Hyperdimensional bundling encoder. Each accepted feature beat is bound with
// its key (optional XOR), added bitwise into per-dimension counters, and once
// the programmed number of features has arrived the counters are reduced by
// strict majority into a binary sample hypervector.
//
// Build option:
//   ENC_BIND_EN  defined   -> accumulated bit is data[d] ^ key[d]
//                undefined -> accumulated bit is data[d]; key is unused
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a new sample (looked at only in IDLE)
//   n_feat     features in this sample, latched on accepted start
//   in_valid   feature beat valid
//   in_ready   encoder accepts a feature beat (ACC only)
//   data       feature hypervector
//   key        binding key for this beat
//   out_valid  enc holds a valid sample hypervector (OUT only)
//   out_ready  downstream accepts enc
//   enc        encoded sample hypervector, registered in THRESH
//   busy       high in any state other than IDLE
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start with a non-zero feature count
// ACC    | accepting feature beats, accumulating per-dimension counts
// THRESH | one cycle: majority threshold of counts into enc
// OUT    | presenting enc until out_ready

module hdc_bundle_encoder #(
  parameter int DIM   = 1024,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_feat,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIM-1:0]   data,
  input  logic [DIM-1:0]   key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIM-1:0]   enc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    THRESH = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           n_feat_q, n_feat_d;
  logic [CNT_W-1:0]           beat_cnt_q, beat_cnt_d;
  logic [DIM-1:0][CNT_W-1:0]  acc_q, acc_d;
  logic [DIM-1:0]             enc_q, enc_d;
  logic [DIM-1:0]             bind_bits;

`ifdef ENC_BIND_EN
  assign bind_bits = data ^ key;
`else
  // key stays on the port so both builds share one footprint.
  logic unused_key;
  assign unused_key = ^key;
  assign bind_bits  = data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_feat_q   <= '0;
      beat_cnt_q <= '0;
      acc_q      <= '0;
      enc_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_feat_q   <= n_feat_d;
      beat_cnt_q <= beat_cnt_d;
      acc_q      <= acc_d;
      enc_q      <= enc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_feat_d   = n_feat_q;
    beat_cnt_d = beat_cnt_q;
    acc_d      = acc_q;
    enc_d      = enc_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        // A zero-feature sample has no majority to take, so it is dropped.
        if (start && (n_feat != '0)) begin
          n_feat_d   = n_feat;
          beat_cnt_d = '0;
          acc_d      = '0;
          state_d    = ACC;
        end
      end

      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int d = 0; d < DIM; d++) begin
            acc_d[d] = acc_q[d] + CNT_W'(bind_bits[d]);
          end
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_d == n_feat_q) begin
            state_d = THRESH;
          end
        end
      end

      THRESH: begin
        // 2*acc vs n_feat at CNT_W+1 bits: strict majority, ties give 0.
        for (int d = 0; d < DIM; d++) begin
          enc_d[d] = ({acc_q[d], 1'b0} > {1'b0, n_feat_q});
        end
        state_d = OUT;
      end

      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign enc = enc_q;

endmodule

// File: doc/hdc_bundle_encoder.md
# hdc_bundle_encoder

Parametrised hyperdimensional bundling encoder: binds each incoming feature hypervector with a per-feature key (XOR), accumulates a runtime-programmable number of features per sample in per-dimension counters, and thresholds the counts by strict majority into a binary sample hypervector. It supersedes the fixed-width, handshake-less accumulate-and-MSB encoder. It sits between the item-memory/feature stream and the associative-memory search stage. Both sides use a valid/ready handshake.

## Interface
- DIM, 1024, hypervector dimension (bits per vector)
- CNT_W, 8, width of feature count and per-dimension accumulators; max features per sample = 2^CNT_W − 1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a new sample; sampled only in IDLE
- n_feat  in  CNT_W  features in this sample; latched on accepted start
- in_valid  in  1  feature beat valid
- in_ready  out  1  encoder accepts a feature beat
- data  in  DIM  feature hypervector
- key  in  DIM  binding key for this beat (ignored when binding compiled out)
- out_valid  out  1  enc holds a valid sample hypervector
- out_ready  in  1  downstream accepts enc
- enc  out  DIM  encoded sample hypervector
- busy  out  1  high in any state other than IDLE

## Operation
- One clock, clk; reset is asynchronous and active-low on rst_n. Reset forces state IDLE, all accumulators and the feature counter to 0, and enc = 0. Outputs go in_ready = 0, out_valid = 0, busy = 0.
- The FSM has four states: IDLE, ACC, THRESH and OUT.
- IDLE: start = 1 with n_feat ≠ 0 latches n_feat, clears every accumulator and the beat counter, and moves to ACC. start with n_feat = 0 is ignored; the block stays in IDLE.
- ACC: in_ready = 1. A beat transfers when in_valid & in_ready.
  - Per beat, bit b = data[d] ^ key[d], and acc[d] += b.
  - The beat counter increments on each beat.
  - The beat that brings the counter to the latched n_feat moves the FSM to THRESH.
  - in_valid low stalls the FSM with no change.
- THRESH: in_ready = 0, lasting one cycle.
  - enc[d] = 1 iff 2·acc[d] > n_feat, compared at CNT_W+1 bits with no overflow.
  - A tie (even n_feat, acc[d] = n_feat/2) gives 0. enc is registered here.
  - The FSM then goes to OUT.
- OUT: out_valid = 1, and enc is held stable until out_ready = 1. That cycle returns the FSM to IDLE with out_valid low the next cycle.
- enc keeps its last value in IDLE and ACC until the next THRESH.
- start is ignored outside IDLE. in_valid is ignored outside ACC.
- Accumulators cannot overflow, because acc[d] ≤ n_feat ≤ 2^CNT_W − 1.
- Reset asserted mid-sample aborts the sample immediately and discards partial counts.

## Timing
- start accepted at edge t: in_ready = 1 from cycle t+1.
- Last beat accepted at edge k: THRESH during cycle k+1, out_valid = 1 from cycle k+2.
- Minimum sample period with no stalls: n_feat + 3 cycles (start, n_feat beats, THRESH, one OUT cycle).
- out_valid/enc hold under backpressure: enc cannot change while out_valid = 1 and out_ready = 0.
- busy rises the cycle after accepted start. It falls the cycle after the OUT handshake.

## Configuration
- Macro ENC_BIND_EN.
- Defined: accumulated bit is data[d] ^ key[d].
- Undefined: accumulated bit is data[d]. The key port remains present but is unused. All other behaviour and timing are identical.

## Test plan
- Reset mid-ACC: DIM=8, n_feat=3, one beat accepted, then rst_n low. Required response: in_ready=0, out_valid=0, busy=0, enc=0. A following sample with n_feat=1, data=8'hA5, key=0 gives enc=8'hA5.
- Majority, odd count (ENC_BIND_EN, DIM=8): n_feat=3, data {8'hFF, 8'h0F, 8'h00}, key 0 on every beat. Required response: enc=8'h0F, and out_valid asserts 2 cycles after the third beat.
- Tie and binding: n_feat=2, beats (data 8'hF0, key 8'h00) and (data 8'hF0, key 8'hFF). The bound bits are 8'hF0 and 8'h0F, so every dimension ties. Required response: enc=8'h00. With the macro undefined the same stimulus gives enc=8'hF0.
- Stalls and backpressure: n_feat=4 with in_valid toggling 1-0-1-0-1-1, then out_ready held 0 for 5 cycles. Required response: exactly 4 beats are counted, and enc and out_valid stay stable for those 5 cycles. The OUT handshake on cycle 6 returns busy to 0 next cycle.
- Boundaries: start with n_feat=0 leaves busy=0. n_feat=255 (CNT_W=8) with data all-ones gives enc = all-ones with no wrap. start pulses during ACC or OUT are ignored.
- Back-to-back: two samples with start asserted in the cycle immediately after the OUT handshake. Required response: the second sample's counts are independent of the first (accumulators cleared).
